qnigma_alu_arb: RTL and testbench
=================================

Name: qnigma_alu_arb

Overview:
- Round-robin arbiter that time-shares one qnigma_alu instance between N requesters, for example qnigma_poly1305 and a future field-arithmetic engine.
- Each requester sees a private ALU-like port: it pulses cal, holds its operands, and waits for its own rdy pulse.
- The arbiter queues requests, issues one operation at a time to the ALU, and routes res/eql back to the issuing requester.
- A watchdog aborts an operation if the ALU never answers.

Parameters:
- N, 2, number of requesters (2..8).
- W, 256, operand/result width; must equal the ALU W.
- TMO, 1024, ALU-busy cycles allowed before abort (≥ 4).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_opa  in  N×W  operand A per requester; held stable from cal until rdy.
- req_opb  in  N×W  operand B per requester; same hold rule.
- req_fld  in  N×pri_t  field select per requester.
- req_op  in  N×4  op per requester {inv,sub,mul,add}; must be one-hot.
- req_cal  in  N  one-cycle request pulse per requester.
- req_res  out  W  result; valid only while req_rdy[i]=1.
- req_eql  out  1  ALU eql; valid only while req_rdy[i]=1.
- req_rdy  out  N  one-cycle completion pulse per requester.
- req_err  out  N  sticky error per requester; cleared only by reset.
- busy  out  1  ALU operation in flight.
- alu_opa, alu_opb  out  W  registered operands to the ALU.
- alu_fld  out  pri_t  registered field select.
- alu_add, alu_mul, alu_sub, alu_inv  out  1  registered op strobes.
- alu_cal  out  1  one-cycle ALU start.
- alu_res  in  W  ALU result.
- alu_eql  in  1  ALU equality flag.
- alu_rdy  in  1  ALU completion pulse.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, pending bits 0, state IDLE, round-robin pointer = N-1 (requester 0 has first priority).
- Pending: req_cal[i] sets pend[i] at the next edge.
  - If pend[i] is already 1, or i is the in-flight requester, the cal is dropped and req_err[i] is set.
  - If req_op[i] is not one-hot, pend[i] is not set, req_err[i] is set, and req_rdy[i] pulses one cycle later with req_res=0.
- FSM, IDLE:
  - If any pend bit is set, grant g = first pending index after the pointer (wrapping N-1 → 0).
  - Latch req_* of g into the alu_* registers and pulse alu_cal for one cycle.
  - Clear pend[g], set pointer = g and busy=1, load watchdog = TMO, go to WAIT.
- FSM, WAIT:
  - On alu_rdy: capture alu_res/alu_eql, pulse req_rdy[g] at the next edge, set busy=0, go to IDLE.
  - Otherwise decrement the watchdog. At 0: req_rdy[g] pulses with req_res=0 and req_eql=0, req_err[g] is set, go to IDLE.
  - alu_rdy arriving in IDLE, or after a timeout, is ignored.
- Latency with the arbiter uncontended: req_cal at cycle 0 → pend at 1 → alu_cal at 2. If alu_rdy is at cycle t, req_rdy is at t+1.
  - Back-to-back issue: the next alu_cal fires no earlier than 2 cycles after the previous req_rdy cycle.
- Simultaneous cal from several requesters: all become pending in the same cycle and are served in round-robin order.
  - No requester waits more than N-1 operations.
- A requester may pulse req_cal in the same cycle as its own req_rdy; this is accepted as a new request.
- alu_* operands and strobes hold their values from issue until the next issue. Only alu_cal is a pulse.
- req_res/req_eql are shared across requesters. A consumer samples them only while its own req_rdy bit is high.
- Reset mid-operation: any in-flight operation and all pending requests are discarded and no req_rdy is produced. The ALU sits on the same reset.

Test Plan:
- Single request, N=2, F1305: requester 0 sends add, opa=2, opb=3 → alu_cal exactly 2 cycles after req_cal; req_rdy[0] one cycle after alu_rdy; req_res=5, req_err=0.
- Simultaneous cal: req0 mul 7×6, req1 add 10+20 → req0 is served first with res=42, then req1 with res=30. The next simultaneous pair serves req1 first.
- Duplicate cal: req1 pulses cal twice while pending → exactly one req_rdy[1]; req_err[1]=1; req_err[0]=0.
- Illegal op: req_op[0]=4'b0011 → req_rdy[0] 2 cycles later with res=0 and req_err[0]=1; alu_cal never asserted.
- Timeout, TMO=8, ALU stub that never raises rdy → req_rdy[g] 8 cycles after alu_cal+1 with res=0 and req_err set. A late alu_rdy produces no extra req_rdy.
- Reset mid-WAIT: rst=0 for 1 cycle while busy → busy=0, no req_rdy. A new request afterwards completes normally (add 1+1 = 2).

Source files
------------

// File: rtl/qnigma_alu_arb.sv
// Round-robin arbiter time-sharing one qnigma_alu among N requesters: req_cal->alu_cal 2 cycles,
// alu_rdy->req_rdy 1 cycle; a cal while already pending or in flight is dropped and flagged in req_err.
package qnigma_alu_arb_pkg;
  typedef enum logic [1:0] {F1305 = 2'd0, F25519 = 2'd1} pri_t;
endpackage

module qnigma_alu_arb
  import qnigma_alu_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int W   = 256,
  parameter int TMO = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0][W-1:0]   req_opa,
  input  logic [N-1:0][W-1:0]   req_opb,
  input  pri_t [N-1:0]          req_fld,
  input  logic [N-1:0][3:0]     req_op,
  input  logic [N-1:0]          req_cal,
  output logic [W-1:0]          req_res,
  output logic                  req_eql,
  output logic [N-1:0]          req_rdy,
  output logic [N-1:0]          req_err,
  output logic                  busy,
  output logic [W-1:0]          alu_opa,
  output logic [W-1:0]          alu_opb,
  output pri_t                  alu_fld,
  output logic                  alu_add,
  output logic                  alu_mul,
  output logic                  alu_sub,
  output logic                  alu_inv,
  output logic                  alu_cal,
  input  logic [W-1:0]          alu_res,
  input  logic                  alu_eql,
  input  logic                  alu_rdy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    bad_q, bad_d;
  logic [N-1:0]    err_q, err_d;
  logic [N-1:0]    rdy_q, rdy_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [W-1:0]    res_q, res_d;
  logic            eql_q, eql_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  pri_t            fld_q, fld_d;
  logic [3:0]      op_q, op_d;
  logic            cal_q, cal_d;

  logic            found;
  logic [IW-1:0]   gsel;
  int              idx;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bad_d   = '0;
    err_d   = err_q;
    rdy_d   = '0;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wdog_d  = wdog_q;
    res_d   = res_q;
    eql_d   = eql_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    fld_d   = fld_q;
    op_d    = op_q;
    cal_d   = 1'b0;
    found   = 1'b0;
    gsel    = '0;
    idx     = 0;

    // Search starts just after the last grant so every requester waits at most N-1 operations.
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && pend_q[IW'(idx)]) begin
        found = 1'b1;
        gsel  = IW'(idx);
      end
    end

    for (int i = 0; i < N; i++) begin
      if (req_cal[i]) begin
        if (pend_q[i] || (state_q == WAIT && gnt_q == IW'(i))) begin
          err_d[i] = 1'b1;
        end else if (!is_onehot(req_op[i])) begin
          err_d[i] = 1'b1;
          bad_d[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
        end
      end
    end

    if (|bad_q) begin
      rdy_d = bad_q;
      res_d = '0;
      eql_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Hold off one cycle after any completion so issues are spaced by at least two cycles.
        if (found && rdy_q == '0) begin
          opa_d        = req_opa[gsel];
          opb_d        = req_opb[gsel];
          fld_d        = req_fld[gsel];
          op_d         = req_op[gsel];
          cal_d        = 1'b1;
          pend_d[gsel] = 1'b0;
          ptr_d        = gsel;
          gnt_d        = gsel;
          wdog_d       = TW'(TMO);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (alu_rdy) begin
          res_d        = alu_res;
          eql_d        = alu_eql;
          rdy_d[gnt_q] = 1'b1;
          state_d      = IDLE;
        end else if (wdog_q == '0) begin
          res_d        = '0;
          eql_d        = 1'b0;
          rdy_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          wdog_d = wdog_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      bad_q   <= '0;
      err_q   <= '0;
      rdy_q   <= '0;
      ptr_q   <= IW'(N - 1);
      gnt_q   <= '0;
      wdog_q  <= '0;
      res_q   <= '0;
      eql_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      fld_q   <= F1305;
      op_q    <= '0;
      cal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wdog_q  <= wdog_d;
      res_q   <= res_d;
      eql_q   <= eql_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      fld_q   <= fld_d;
      op_q    <= op_d;
      cal_q   <= cal_d;
    end
  end

  assign req_res = res_q;
  assign req_eql = eql_q;
  assign req_rdy = rdy_q;
  assign req_err = err_q;
  assign busy    = (state_q == WAIT);
  assign alu_opa = opa_q;
  assign alu_opb = opb_q;
  assign alu_fld = fld_q;
  assign alu_add = op_q[0];
  assign alu_mul = op_q[1];
  assign alu_sub = op_q[2];
  assign alu_inv = op_q[3];
  assign alu_cal = cal_q;

endmodule

// File: tb/tb_qnigma_alu_arb.sv
// Directed bench for qnigma_alu_arb with a small ALU stub of fixed latency that can be muted.
module tb_qnigma_alu_arb;
  import qnigma_alu_arb_pkg::*;

  localparam int N   = 2;
  localparam int W   = 16;
  localparam int TMO = 8;
  localparam int LAT = 3;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0100;

  logic                clk;
  logic                rst;
  logic [N-1:0][W-1:0] req_opa;
  logic [N-1:0][W-1:0] req_opb;
  pri_t [N-1:0]        req_fld;
  logic [N-1:0][3:0]   req_op;
  logic [N-1:0]        req_cal;
  logic [W-1:0]        req_res;
  logic                req_eql;
  logic [N-1:0]        req_rdy;
  logic [N-1:0]        req_err;
  logic                busy;
  logic [W-1:0]        alu_opa;
  logic [W-1:0]        alu_opb;
  pri_t                alu_fld;
  logic                alu_add, alu_mul, alu_sub, alu_inv, alu_cal;
  logic [W-1:0]        alu_res;
  logic                alu_eql;
  logic                alu_rdy;

  int vecs = 0;
  int errs = 0;

  qnigma_alu_arb #(.N(N), .W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_opa(req_opa), .req_opb(req_opb), .req_fld(req_fld), .req_op(req_op), .req_cal(req_cal),
    .req_res(req_res), .req_eql(req_eql), .req_rdy(req_rdy), .req_err(req_err), .busy(busy),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_fld(alu_fld),
    .alu_add(alu_add), .alu_mul(alu_mul), .alu_sub(alu_sub), .alu_inv(alu_inv), .alu_cal(alu_cal),
    .alu_res(alu_res), .alu_eql(alu_eql), .alu_rdy(alu_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU stub: answers LAT cycles after alu_cal unless muted; kick forces a stray alu_rdy.
  logic stub_mute;
  logic kick;
  int   stub_cnt;
  initial begin
    alu_rdy  = 1'b0;
    alu_res  = '0;
    alu_eql  = 1'b0;
    stub_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      alu_rdy = kick;
      if (!rst) begin
        stub_cnt = 0;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          alu_rdy = 1'b1;
          alu_eql = (alu_opa == alu_opb);
          alu_res = alu_add ? alu_opa + alu_opb :
                    alu_mul ? alu_opa * alu_opb :
                    alu_sub ? alu_opa - alu_opb : ~alu_opa;
        end
      end else if (alu_cal && !stub_mute) begin
        stub_cnt = LAT;
      end
    end
  end

  // Event recorder, sampled on the falling edge.
  int             cyc = 0;
  int             cal_n = 0;
  int             cal_cyc = 0;
  int             alurdy_cyc = 0;
  int             rdy_n [N];
  int             rdy_cyc [N];
  logic [W-1:0]   rdy_res [N];
  logic           rdy_eql [N];
  initial begin
    for (int i = 0; i < N; i++) begin
      rdy_n[i] = 0; rdy_cyc[i] = 0; rdy_res[i] = '0; rdy_eql[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (alu_cal) begin cal_n++; cal_cyc = cyc; end
      if (alu_rdy) alurdy_cyc = cyc;
      for (int i = 0; i < N; i++) begin
        if (req_rdy[i]) begin
          rdy_n[i]++; rdy_cyc[i] = cyc; rdy_res[i] = req_res; rdy_eql[i] = req_eql;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i]  = op;
    req_opa[i] = a;
    req_opb[i] = b;
    req_fld[i] = F1305;
    req_cal[i] = 1'b1;
  endtask

  task automatic wait_rdy(input int i, input int n0, output bit to);
    int k = 0;
    while (rdy_n[i] == n0 && k < 40) begin
      tick();
      k++;
    end
    to = (rdy_n[i] == n0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (req_rdy !== '0 || req_err !== '0) begin
      errs++; $display("FAIL reset_req: rdy=%b err=%b want 0/0", req_rdy, req_err); end
    vecs++; if ({alu_cal, alu_add, alu_mul, alu_sub, alu_inv} !== 5'b0) begin
      errs++; $display("FAIL reset_strobes: got %b want 0", {alu_cal, alu_add, alu_mul, alu_sub, alu_inv}); end
    vecs++; if (alu_opa !== '0 || alu_opb !== '0 || req_res !== '0) begin
      errs++; $display("FAIL reset_data: opa=%h opb=%h res=%h want 0", alu_opa, alu_opb, req_res); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int c0, n0, cn0;
    bit to;
    c0 = cyc; n0 = rdy_n[0]; cn0 = cal_n;
    issue(0, OP_ADD, 16'd2, 16'd3);
    tick();
    req_cal = '0;
    wait_rdy(0, n0, to);
    vecs++; if (to) begin errs++; $display("FAIL single_timeout: no req_rdy[0] within 40 cycles"); end
    vecs++; if (cal_n - cn0 !== 1) begin errs++; $display("FAIL single_calcount: got %0d want 1", cal_n - cn0); end
    vecs++; if (cal_cyc - c0 !== 2) begin errs++; $display("FAIL single_cal_lat: got %0d want 2", cal_cyc - c0); end
    vecs++; if (rdy_cyc[0] - alurdy_cyc !== 1) begin
      errs++; $display("FAIL single_rdy_lat: got %0d want 1", rdy_cyc[0] - alurdy_cyc); end
    vecs++; if (rdy_res[0] !== 16'd5) begin errs++; $display("FAIL single_res: got %0d want 5", rdy_res[0]); end
    vecs++; if (req_err !== 2'b00) begin errs++; $display("FAIL single_err: got %b want 00", req_err); end
  endtask

  task automatic test_simultaneous();
    int n0, n1;
    bit to;
    do_reset();
    n1 = rdy_n[1];
    issue(0, OP_MUL, 16'd7, 16'd6);
    issue(1, OP_ADD, 16'd10, 16'd20);
    tick();
    req_cal = '0;
    wait_rdy(1, n1, to);
    vecs++; if (to) begin errs++; $display("FAIL simul1_timeout: no req_rdy[1] within 40 cycles"); end
    vecs++; if (rdy_cyc[0] >= rdy_cyc[1]) begin
      errs++; $display("FAIL simul1_order: rdy0 at %0d rdy1 at %0d want rdy0 first", rdy_cyc[0], rdy_cyc[1]); end
    vecs++; if (rdy_res[0] !== 16'd42 || rdy_res[1] !== 16'd30) begin
      errs++; $display("FAIL simul1_res: got %0d/%0d want 42/30", rdy_res[0], rdy_res[1]); end
    vecs++; if (cal_cyc - rdy_cyc[0] < 2) begin
      errs++; $display("FAIL simul1_gap: next alu_cal %0d cycles after req_rdy, want >=2", cal_cyc - rdy_cyc[0]); end
    // A lone requester-0 op moves the pointer to 0, so the next pair starts with requester 1.
    n0 = rdy_n[0];
    issue(0, OP_ADD, 16'd100, 16'd1);
    tick();
    req_cal = '0;
    wait_rdy(0, n0, to);
    vecs++; if (to || rdy_res[0] !== 16'd101) begin
      errs++; $display("FAIL simul_lone: to=%0b res=%0d want 0/101", to, rdy_res[0]); end
    n0 = rdy_n[0];
    issue(0, OP_ADD, 16'd1, 16'd2);
    issue(1, OP_SUB, 16'd9, 16'd4);
    tick();
    req_cal = '0;
    wait_rdy(0, n0, to);
    vecs++; if (to) begin errs++; $display("FAIL simul2_timeout: no req_rdy[0] within 40 cycles"); end
    vecs++; if (rdy_cyc[1] >= rdy_cyc[0]) begin
      errs++; $display("FAIL simul2_order: rdy1 at %0d rdy0 at %0d want rdy1 first", rdy_cyc[1], rdy_cyc[0]); end
    vecs++; if (rdy_res[0] !== 16'd3 || rdy_res[1] !== 16'd5) begin
      errs++; $display("FAIL simul2_res: got %0d/%0d want 3/5", rdy_res[0], rdy_res[1]); end
  endtask

  task automatic test_duplicate();
    int n1;
    bit to;
    n1 = rdy_n[1];
    issue(1, OP_ADD, 16'd4, 16'd4);
    tick();
    tick();
    req_cal = '0;
    wait_rdy(1, n1, to);
    repeat (15) tick();
    vecs++; if (to || rdy_n[1] - n1 !== 1) begin
      errs++; $display("FAIL dup_count: to=%0b rdy pulses=%0d want 1", to, rdy_n[1] - n1); end
    vecs++; if (rdy_res[1] !== 16'd8 || rdy_eql[1] !== 1'b1) begin
      errs++; $display("FAIL dup_res: res=%0d eql=%b want 8/1", rdy_res[1], rdy_eql[1]); end
    vecs++; if (req_err !== 2'b10) begin errs++; $display("FAIL dup_err: got %b want 10", req_err); end
  endtask

  task automatic test_illegal_op();
    int c0, n0, cn0;
    bit to;
    c0 = cyc; n0 = rdy_n[0]; cn0 = cal_n;
    issue(0, 4'b0011, 16'd5, 16'd6);
    tick();
    req_cal = '0;
    wait_rdy(0, n0, to);
    repeat (10) tick();
    vecs++; if (to || rdy_cyc[0] - c0 !== 2) begin
      errs++; $display("FAIL illegal_lat: to=%0b latency=%0d want 2", to, rdy_cyc[0] - c0); end
    vecs++; if (rdy_res[0] !== '0) begin errs++; $display("FAIL illegal_res: got %0d want 0", rdy_res[0]); end
    vecs++; if (req_err !== 2'b11) begin errs++; $display("FAIL illegal_err: got %b want 11", req_err); end
    vecs++; if (cal_n !== cn0 || rdy_n[0] - n0 !== 1) begin
      errs++; $display("FAIL illegal_nocal: alu_cal count %0d rdy count %0d want 0/1", cal_n - cn0, rdy_n[0] - n0); end
  endtask

  task automatic test_timeout();
    int n0, n1;
    bit to;
    do_reset();
    n1 = rdy_n[1];
    issue(1, OP_ADD, 16'd3, 16'd4);
    tick();
    req_cal = '0;
    wait_rdy(1, n1, to);
    vecs++; if (to || rdy_res[1] !== 16'd7) begin
      errs++; $display("FAIL tmo_pre: to=%0b res=%0d want 0/7", to, rdy_res[1]); end
    stub_mute = 1'b1;
    n0 = rdy_n[0];
    issue(0, OP_ADD, 16'd1, 16'd2);
    tick();
    req_cal = '0;
    wait_rdy(0, n0, to);
    vecs++; if (to || rdy_cyc[0] - cal_cyc !== TMO + 1) begin
      errs++; $display("FAIL tmo_lat: to=%0b got %0d want %0d", to, rdy_cyc[0] - cal_cyc, TMO + 1); end
    vecs++; if (rdy_res[0] !== '0 || rdy_eql[0] !== 1'b0) begin
      errs++; $display("FAIL tmo_res: res=%0d eql=%b want 0/0", rdy_res[0], rdy_eql[0]); end
    vecs++; if (req_err !== 2'b01 || busy !== 1'b0) begin
      errs++; $display("FAIL tmo_err: err=%b busy=%b want 01/0", req_err, busy); end
    n0 = rdy_n[0]; n1 = rdy_n[1];
    kick = 1'b1;
    tick();
    kick = 1'b0;
    repeat (5) tick();
    vecs++; if (rdy_n[0] !== n0 || rdy_n[1] !== n1) begin
      errs++; $display("FAIL tmo_late: extra rdy %0d/%0d want 0/0", rdy_n[0] - n0, rdy_n[1] - n1); end
    stub_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n1, k;
    bit to;
    n1 = rdy_n[1];
    issue(1, OP_ADD, 16'd1, 16'd1);
    tick();
    req_cal = '0;
    k = 0;
    while (busy !== 1'b1 && k < 10) begin tick(); k++; end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_busy: got %b want 1 before reset", busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_idle: got %b want 0", busy); end
    repeat (10) tick();
    vecs++; if (rdy_n[1] !== n1) begin errs++; $display("FAIL rmid_norfy: got %0d rdy want 0", rdy_n[1] - n1); end
    issue(1, OP_ADD, 16'd1, 16'd1);
    tick();
    req_cal = '0;
    wait_rdy(1, n1, to);
    vecs++; if (to || rdy_res[1] !== 16'd2 || rdy_eql[1] !== 1'b1) begin
      errs++; $display("FAIL rmid_after: to=%0b res=%0d eql=%b want 0/2/1", to, rdy_res[1], rdy_eql[1]); end
  endtask

  initial begin
    rst       = 1'b0;
    req_opa   = '0;
    req_opb   = '0;
    req_fld   = {N{F1305}};
    req_op    = '0;
    req_cal   = '0;
    stub_mute = 1'b0;
    kick      = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_duplicate();
    test_illegal_op();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
